// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack command sequencer: opcodes, error codes, FSM states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package stack_seq_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_DUP   = 3'd3;
    localparam logic [2:0] OP_SWAP  = 3'd4;
    localparam logic [2:0] OP_ADD   = 3'd5;
    localparam logic [2:0] OP_SUB   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_FAULT = 2'd3;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Index of the final strobe for fixed-length sequences (CLEAR uses its own counter).
    function automatic logic [1:0] last_step(input logic [2:0] op);
        logic [1:0] s;
        s = 2'd0;
        case (op)
            OP_ADD, OP_SUB: s = 2'd2;
            OP_SWAP:        s = 2'd3;
            default:        s = 2'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Add/subtract of the latched stack operands (a = top-minus-one, b = top), modulo 2^DW.
// Latency: combinational.
// Backpressure: none; STACK_SEQ_FLAGS_EN adds zero and carry/borrow outputs.
module stack_seq_alu
    import stack_seq_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          sub_i,
    output logic [DW-1:0] y_o
`ifdef STACK_SEQ_FLAGS_EN
    ,
    output logic          z_o,
    output logic          c_o
`endif
);

`ifdef STACK_SEQ_FLAGS_EN
    logic [DW:0] sum;

    // One extra bit: carry out for ADD, borrow (a < b) for SUB.
    always_comb begin
        sum = sub_i ? ({1'b0, a_i} - {1'b0, b_i}) : ({1'b0, a_i} + {1'b0, b_i});
        y_o = sum[DW-1:0];
        z_o = (sum[DW-1:0] == '0);
        c_o = sum[DW];
    end
`else
    // Plain wrap-around arithmetic.
    always_comb begin
        y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
    end
`endif

endmodule

// File: rtl/stack_seq.sv
// Stack command sequencer: splits one command into single-cycle push/pop strobes, tracks depth.
// Latency: NOP/refused 1, PUSH/POP/DUP 2, ADD/SUB 4, SWAP 5, CLEAR depth+1 cycles to done.
// Backpressure: cmd_ready only in IDLE; optional STACK_SEQ_FLAGS_EN adds flag_z/flag_c.
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [DW-1:0] cmd_imm,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [DW-1:0] result,
    output logic [5:0]    depth,
    output logic          stack_en,
    output logic          stack_rst,
    output logic          stack_op,
    output logic          stack_op_en,
    output logic [DW-1:0] stack_din,
    input  logic          stack_overflow,
    input  logic          stack_underflow,
    input  logic [DW-1:0] stack_top,
    input  logic [DW-1:0] stack_top_mo
`ifdef STACK_SEQ_FLAGS_EN
    ,
    output logic          flag_z,
    output logic          flag_c
`endif
);

    localparam logic [5:0] DEPTH_W = 6'(DEPTH);

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] top_q, top_d;
    logic [DW-1:0] tmo_q, tmo_d;
    logic [1:0]    step_q, step_d;
    logic [5:0]    clr_q, clr_d;
    logic [5:0]    depth_q, depth_d;
    logic [DW-1:0] result_q, result_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic [DW-1:0] alu_y;
    logic          fault;
    logic          last;
    logic          need1, need2, need_room;

`ifdef STACK_SEQ_FLAGS_EN
    logic alu_z, alu_c;
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;
`endif

    stack_seq_alu #(.DW(DW)) u_alu (
        .a_i   (tmo_q),
        .b_i   (top_q),
        .sub_i (op_q == OP_SUB),
        .y_o   (alu_y)
`ifdef STACK_SEQ_FLAGS_EN
        ,
        .z_o   (alu_z),
        .c_o   (alu_c)
`endif
    );

    assign fault = stack_overflow | stack_underflow;

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_INIT;
            op_q     <= OP_NOP;
            imm_q    <= '0;
            top_q    <= '0;
            tmo_q    <= '0;
            step_q   <= 2'd0;
            clr_q    <= 6'd0;
            depth_q  <= 6'd0;
            result_q <= '0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            imm_q    <= imm_d;
            top_q    <= top_d;
            tmo_q    <= tmo_d;
            step_q   <= step_d;
            clr_q    <= clr_d;
            depth_q  <= depth_d;
            result_q <= result_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    // Next-state, legality check at acceptance, and per-step stack strobes.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        top_d       = top_q;
        tmo_d       = tmo_q;
        step_d      = step_q;
        clr_d       = clr_q;
        depth_d     = depth_q;
        result_d    = result_q;
        err_d       = err_q;
        code_d      = code_q;
        stack_op_en = 1'b0;
        stack_op    = 1'b0;
        stack_din   = '0;
        last        = 1'b0;
        need1       = (cmd_op == OP_POP) || (cmd_op == OP_DUP);
        need2       = (cmd_op == OP_SWAP) || (cmd_op == OP_ADD) || (cmd_op == OP_SUB);
        need_room   = (cmd_op == OP_PUSH) || (cmd_op == OP_DUP);

        case (state_q)
            S_INIT: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    imm_d  = cmd_imm;
                    top_d  = stack_top;
                    tmo_d  = stack_top_mo;
                    step_d = 2'd0;
                    clr_d  = depth_q;
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
                    if ((need1 && depth_q == 6'd0) || (need2 && depth_q < 6'd2)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        code_d  = ERR_UNDER;
                    end else if (need_room && depth_q >= DEPTH_W) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        code_d  = ERR_OVER;
                    end else if (cmd_op == OP_NOP || (cmd_op == OP_CLEAR && depth_q == 6'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (fault) begin
                    // Abort without a strobe; tracked depth is left as is.
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    code_d  = ERR_FAULT;
                end else begin
                    stack_op_en = 1'b1;
                    case (op_q)
                        OP_PUSH: begin stack_op = 1'b1; stack_din = imm_q; end
                        OP_POP:  stack_op = 1'b0;
                        OP_DUP:  begin stack_op = 1'b1; stack_din = top_q; end
                        OP_SWAP: begin
                            stack_op  = step_q[1];
                            stack_din = (step_q == 2'd2) ? top_q : tmo_q;
                        end
                        OP_ADD, OP_SUB: begin
                            stack_op  = (step_q == 2'd2);
                            stack_din = alu_y;
                        end
                        OP_CLEAR: stack_op = 1'b0;
                        default:  stack_op_en = 1'b0;
                    endcase
                    if (stack_op_en) begin
                        depth_d = stack_op ? (depth_q + 6'd1) : (depth_q - 6'd1);
                    end
                    step_d = step_q + 2'd1;
                    clr_d  = clr_q - 6'd1;
                    last   = (op_q == OP_CLEAR) ? (clr_q == 6'd1) : (step_q == last_step(op_q));
                    if (last) begin
                        state_d = S_DONE;
                        if (op_q == OP_POP) begin
                            result_d = top_q;
                        end else if (op_q == OP_ADD || op_q == OP_SUB) begin
                            result_d = alu_y;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
                code_d  = ERR_NONE;
            end
            default: state_d = S_INIT;
        endcase
    end

`ifdef STACK_SEQ_FLAGS_EN
    // Flags follow a successful ADD/SUB; every other completion clears them.
    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (state_q != S_DONE && state_d == S_DONE) begin
            if (state_q == S_ISSUE && !fault && (op_q == OP_ADD || op_q == OP_SUB)) begin
                flag_z_d = alu_z;
                flag_c_d = alu_c;
            end else begin
                flag_z_d = 1'b0;
                flag_c_d = 1'b0;
            end
        end
    end

    // Flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign err_code  = code_q;
    assign result    = result_q;
    assign depth     = depth_q;
    assign stack_en  = 1'b1;
    assign stack_rst = (state_q == S_INIT);

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Command sequencer that drives the nanoRisc operand stack from the initiator side.
- Accepts one stack-machine command per valid/ready handshake and breaks it into single-cycle push/pop operations on the stack port.
- Reads stack top and top-minus-one, computes results and returns done/err to the core control unit.
- Keeps its own depth count so illegal commands are refused before any stack operation is issued.

Parameters:
- DEPTH, 32, stack capacity in entries; must match the stack instance.
- DW, 8, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode (see Behaviour).
- cmd_imm  in  DW  immediate for PUSH.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; command refused or aborted.
- err_code  out  2  0 none, 1 underflow, 2 overflow, 3 stack fault.
- result  out  DW  POP value or ADD/SUB result; held until next done.
- depth  out  6  tracked entry count, 0..DEPTH.
- stack_en  out  1  stack enable.
- stack_rst  out  1  stack synchronous reset request.
- stack_op  out  1  0 = pop, 1 = push.
- stack_op_en  out  1  one-cycle operation strobe.
- stack_din  out  DW  push data.
- stack_overflow  in  1  stack overflow flag.
- stack_underflow  in  1  stack underflow flag.
- stack_top  in  DW  stack top, asynchronous read.
- stack_top_mo  in  DW  top minus one, asynchronous read.

Behaviour:
- Reset values:
  - State INIT; depth 0.
  - cmd_ready, done, err, stack_op_en and stack_op are 0; err_code 0; result 0; stack_din 0.
  - stack_en 1; stack_rst 1.
- INIT lasts exactly 1 cycle after reset deassertion: stack_rst=1, stack_en=1, then go to IDLE with stack_rst=0. stack_en stays 1 from then on.
- Opcodes and net stack effect:
  - 0 NOP: done next cycle, no stack op.
  - 1 PUSH: push imm.
  - 2 POP: result=top; pop.
  - 3 DUP: push top.
  - 4 SWAP: pop, pop, push old top, push old top_mo.
  - 5 ADD: pop, pop, push top_mo+top.
  - 6 SUB: pop, pop, push top_mo-top.
  - 7 CLEAR: pop depth times.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on the edge where cmd_valid & cmd_ready.
  - At that edge cmd_op, cmd_imm, stack_top and stack_top_mo are latched.
- Legality is checked at acceptance, against the tracked depth:
  - POP and DUP need depth≥1; SWAP, ADD and SUB need depth≥2. Otherwise err_code=1.
  - PUSH and DUP need depth<DEPTH. Otherwise err_code=2.
  - Illegal command: no stack op issued; done=err=1 on the next cycle; state returns to IDLE.
- States: INIT, IDLE, ISSUE, DONE.
  - ISSUE drives one stack_op_en strobe per cycle, using a 2-bit step counter (a 6-bit counter for CLEAR).
  - After the last strobe, go to DONE. DONE drives done=1 for one cycle, then IDLE.
- Latency from acceptance to done:
  - NOP 1 cycle; PUSH/POP/DUP 2; ADD/SUB 4; SWAP 5; CLEAR depth+1.
  - CLEAR with depth=0 behaves as NOP.
- Arithmetic: modulo 2^DW, no saturation. Examples: 0xFF+0x01=0x00; 0x00-0x01=0xFF.
- depth updates on the same edge as each strobe: +1 for push, -1 for pop.
- Fault handling: stack_overflow or stack_underflow sampled high in ISSUE aborts the sequence.
  - Goes to DONE with err=1, err_code=3.
  - depth is left at its tracked value.
- reset mid-sequence: immediate return to INIT; any in-flight command is dropped with no done.
- err_code and result are valid only while done=1. result is unchanged on error.

Optional Feature:
- Macro STACK_SEQ_FLAGS_EN.
- Defined: adds outputs flag_z and flag_c (1 bit each), registered with done for ADD/SUB.
  - flag_z=(result==0).
  - flag_c = carry out of ADD, or borrow of SUB (top_mo<top).
  - Other ops clear both flags. Reset value 0.
- Undefined: ports are absent; no flag logic.

Decomposition:
- Package stack_seq_pkg holds:
  - opcode localparams OP_NOP..OP_CLEAR;
  - err codes ERR_NONE, ERR_UNDER, ERR_OVER, ERR_FAULT;
  - state encodings INIT/IDLE/ISSUE/DONE.
- One sub-module, stack_seq_alu: combinational add/sub of the latched operands, plus z/c when STACK_SEQ_FLAGS_EN is defined.

Test Plan:
- Reset → stack_rst high for 1 cycle after deassert; cmd_ready=1 on the following cycle; depth=0.
- PUSH 0x12, PUSH 0x34, ADD → ADD done 4 cycles after acceptance; result=0x46; depth=1; stack_top=0x46.
- PUSH 0x05, PUSH 0x07, SUB → result=0xFE; with STACK_SEQ_FLAGS_EN, flag_c=1 and flag_z=0.
- POP with depth=0 → done=err=1 with err_code=1 one cycle later; no stack_op_en strobe; depth stays 0.
- 32 PUSHes then DUP → DUP refused with err_code=2; depth=32. CLEAR → 32 pop strobes; done at cycle 33; depth=0.
- PUSH 0xAA, PUSH 0xBB, SWAP → stack_top=0xAA, stack_top_mo=0xBB. Assert reset during a second SWAP → no done; INIT re-entered; depth=0.
